// File: rtl/lfsr_sequence_checker.sv
// Receive-side checker for the XNOR-feedback LFSR word stream: SEARCH -> VERIFY -> LOCKED.
// Define LFSR_CHECK_ERR_COUNT_EN to build the saturating error counter (otherwise error_count is 0).
module lfsr_sequence_checker #(
  parameter int NUM_BITS      = 32,
  parameter int LOCK_COUNT    = 8,
  parameter int UNLOCK_ERRORS = 4,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_BITS-1:0]      data_in,
  input  logic                     data_valid,
  input  logic                     clear_errors,
  output logic                     locked,
  output logic                     error,
  output logic [ERR_CNT_WIDTH-1:0] error_count
);

  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam int BAD_W  = $clog2(UNLOCK_ERRORS + 1);

  function automatic logic [31:0] tb(input int t);
    return 32'h1 << (t - 1);
  endfunction

  // Feedback taps as a bit mask, tap N selecting word bit N-1.
  function automatic logic [31:0] tap_mask(input int n);
    case (n)
      3:  return tb(3)  | tb(2);
      4:  return tb(4)  | tb(3);
      5:  return tb(5)  | tb(3);
      6:  return tb(6)  | tb(5);
      7:  return tb(7)  | tb(6);
      8:  return tb(8)  | tb(6)  | tb(5)  | tb(4);
      9:  return tb(9)  | tb(5);
      10: return tb(10) | tb(7);
      11: return tb(11) | tb(9);
      12: return tb(12) | tb(6)  | tb(4)  | tb(1);
      13: return tb(13) | tb(4)  | tb(3)  | tb(1);
      14: return tb(14) | tb(5)  | tb(3)  | tb(1);
      15: return tb(15) | tb(14);
      16: return tb(16) | tb(15) | tb(13) | tb(4);
      17: return tb(17) | tb(14);
      18: return tb(18) | tb(11);
      19: return tb(19) | tb(6)  | tb(2)  | tb(1);
      20: return tb(20) | tb(17);
      21: return tb(21) | tb(19);
      22: return tb(22) | tb(21);
      23: return tb(23) | tb(18);
      24: return tb(24) | tb(23) | tb(22) | tb(17);
      25: return tb(25) | tb(22);
      26: return tb(26) | tb(6)  | tb(2)  | tb(1);
      27: return tb(27) | tb(5)  | tb(2)  | tb(1);
      28: return tb(28) | tb(25);
      29: return tb(29) | tb(27);
      30: return tb(30) | tb(6)  | tb(4)  | tb(1);
      31: return tb(31) | tb(28);
      32: return tb(32) | tb(22) | tb(2)  | tb(1);
      default: return 32'h0;
    endcase
  endfunction

  localparam logic [NUM_BITS-1:0] TAPS = NUM_BITS'(tap_mask(NUM_BITS));

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  state_t              state_q, state_d;
  logic [NUM_BITS-1:0] prev_q, prev_d;
  logic [GOOD_W-1:0]   good_q, good_d;
  logic [BAD_W-1:0]    bad_q, bad_d;
  logic                err_q, err_d;
  logic [NUM_BITS-1:0] expected;
  logic                match, all_ones;

  assign expected = {prev_q[NUM_BITS-2:0], ~^(prev_q & TAPS)};
  assign match    = (data_in == expected);
  assign all_ones = &data_in;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    good_d  = good_q;
    bad_d   = bad_q;
    err_d   = 1'b0;
    if (data_valid) begin
      case (state_q)
        SEARCH: begin
          if (!all_ones) begin
            prev_d  = data_in;
            good_d  = '0;
            state_d = VERIFY;
          end
        end
        VERIFY: begin
          prev_d = data_in;
          if (match) begin
            if (good_q == GOOD_W'(LOCK_COUNT - 1)) begin
              state_d = LOCKED;
              bad_d   = '0;
            end else begin
              good_d = good_q + GOOD_W'(1);
            end
          end else begin
            good_d = '0;
            if (all_ones) state_d = SEARCH;
          end
        end
        LOCKED: begin
          if (match) begin
            prev_d = data_in;
            bad_d  = '0;
          end else begin
            // Flywheel on the prediction so a single corrupted word costs one error, not two.
            prev_d = expected;
            err_d  = 1'b1;
            bad_d  = bad_q + BAD_W'(1);
            if (bad_q == BAD_W'(UNLOCK_ERRORS - 1)) begin
              state_d = SEARCH;
              good_d  = '0;
            end
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= SEARCH;
      prev_q  <= '0;
      good_q  <= '0;
      bad_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      err_q   <= err_d;
    end
  end

  assign locked = (state_q == LOCKED);
  assign error  = err_q;

`ifdef LFSR_CHECK_ERR_COUNT_EN
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err_cnt_q <= '0;
    end else if (clear_errors) begin
      err_cnt_q <= '0;
    end else if (err_d && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + ERR_CNT_WIDTH'(1);
    end
  end

  assign error_count = err_cnt_q;
`else
  logic unused_clear_errors;
  assign unused_clear_errors = clear_errors;
  assign error_count         = '0;
`endif

endmodule

// File: tb/tb_lfsr_sequence_checker.sv
// Scoreboard bench for lfsr_sequence_checker (8-bit, LOCK_COUNT=4, UNLOCK_ERRORS=4, 4-bit counter):
// directed scenarios plus randomized streams checked against a behavioural reference model.
module tb_lfsr_sequence_checker;

  localparam int NB   = 8;
  localparam int LOCK = 4;
  localparam int UNL  = 4;
  localparam int CW   = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [NB-1:0] data_in = '0;
  logic          data_valid = 1'b0;
  logic          clear_errors = 1'b0;
  logic          locked, error;
  logic [CW-1:0] error_count;

  lfsr_sequence_checker #(
    .NUM_BITS(NB), .LOCK_COUNT(LOCK), .UNLOCK_ERRORS(UNL), .ERR_CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .data_valid(data_valid),
    .clear_errors(clear_errors), .locked(locked), .error(error), .error_count(error_count)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else pass_cnt++;
  endtask

  // ---------------- reference model ----------------
  typedef enum {M_SEARCH, M_VERIFY, M_LOCKED} mode_t;
  typedef struct {logic locked; logic error; logic [CW-1:0] cnt;} exp_t;

  exp_t  sb[$];
  mode_t m_mode = M_SEARCH;
  logic [NB-1:0] m_prev = '0;
  int    m_good = 0, m_bad = 0, m_cnt = 0;
  bit    m_err = 0;
  int    taps[4] = '{8, 6, 5, 4};

  function automatic logic [NB-1:0] nxt(input logic [NB-1:0] w);
    bit x = 0;
    foreach (taps[i]) x ^= w[taps[i]-1];
    return {w[NB-2:0], ~x};
  endfunction

  function automatic int exp_cnt(input int n);
`ifdef LFSR_CHECK_ERR_COUNT_EN
    return n;
`else
    return 0;
`endif
  endfunction

  task automatic model(input bit rst, input bit v, input logic [NB-1:0] d, input bit clr);
    logic [NB-1:0] e;
    if (!rst) begin
      m_mode = M_SEARCH; m_prev = '0; m_good = 0; m_bad = 0; m_err = 0; m_cnt = 0;
      return;
    end
    m_err = 0;
    if (clr) m_cnt = 0;
    if (!v) return;
    e = nxt(m_prev);
    case (m_mode)
      M_SEARCH: if (d != 8'hFF) begin m_prev = d; m_good = 0; m_mode = M_VERIFY; end
      M_VERIFY: begin
        m_prev = d;
        if (d == e) begin
          if (m_good == LOCK - 1) begin m_mode = M_LOCKED; m_bad = 0; end
          else m_good++;
        end else begin
          m_good = 0;
          if (d == 8'hFF) m_mode = M_SEARCH;
        end
      end
      M_LOCKED: begin
        if (d == e) begin m_prev = d; m_bad = 0; end
        else begin
          m_prev = e; m_err = 1; m_bad++;
          if (!clr && m_cnt < (1 << CW) - 1) m_cnt++;
          if (m_bad == UNL) begin m_mode = M_SEARCH; m_good = 0; end
        end
      end
    endcase
  endtask

  // One clock of stimulus: drive at the falling edge, predict, enqueue the expectation.
  task automatic drive(input bit rst, input bit v, input logic [NB-1:0] d, input bit clr);
    exp_t x;
    @(negedge clk);
    reset_n = rst; data_valid = v; data_in = d; clear_errors = clr;
    model(rst, v, d, clr);
    x.locked = (m_mode == M_LOCKED);
    x.error  = m_err;
    x.cnt    = CW'(exp_cnt(m_cnt));
    sb.push_back(x);
  endtask

  // Monitor: every output sample after an edge is compared with the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("sb_locked", 32'(locked), 32'(e.locked));
        check("sb_error", 32'(error), 32'(e.error));
        check("sb_error_count", 32'(error_count), 32'(e.cnt));
      end
    end
  end

  task automatic wait_out();
    @(posedge clk);
    #1;
  endtask

  logic [NB-1:0] gen;

  task automatic do_reset();
    drive(0, 1, 8'h00, 0);
  endtask

  task automatic lock_up();
    logic [NB-1:0] seq[5] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F};
    foreach (seq[i]) drive(1, 1, seq[i], 0);
    gen = 8'h1E;
  endtask

  task automatic send_good();
    drive(1, 1, gen, 0);
    gen = nxt(gen);
  endtask

  initial begin
    int pct;
    int r;
    // Reset state
    do_reset();
    wait_out();
    check("reset_locked", 32'(locked), 0);
    check("reset_count", 32'(error_count), 0);

    // Clean lock on 00,01,03,07,0F then 1E
    lock_up();
    wait_out();
    check("lock_after_0f", 32'(locked), 1);
    send_good();
    wait_out();
    check("no_error_clean", 32'(error), 0);

    // All-ones ignored in SEARCH
    do_reset();
    repeat (3) drive(1, 1, 8'hFF, 0);
    wait_out();
    check("ff_no_lock", 32'(locked), 0);
    lock_up();
    wait_out();
    check("lock_after_ff", 32'(locked), 1);

    // Single corrupted word 1E -> 5E
    drive(1, 1, 8'h5E, 0);
    gen = nxt(gen);
    wait_out();
    check("single_err_pulse", 32'(error), 1);
    check("single_err_count", 32'(error_count), 32'(exp_cnt(1)));
    send_good();
    wait_out();
    check("single_err_once", 32'(error), 0);
    check("single_err_locked", 32'(locked), 1);

    // Four consecutive mismatches drop lock
    do_reset();
    lock_up();
    repeat (3) begin drive(1, 1, gen ^ 8'h81, 0); gen = nxt(gen); end
    wait_out();
    check("three_err_still_locked", 32'(locked), 1);
    drive(1, 1, gen ^ 8'h81, 0);
    gen = nxt(gen);
    wait_out();
    check("unlock_after_four", 32'(locked), 0);
    check("four_err_count", 32'(error_count), 32'(exp_cnt(4)));

    // Gaps, then clear_errors alongside a mismatch
    do_reset();
    lock_up();
    repeat (3) begin
      send_good();
      repeat (5) drive(1, 0, 8'($urandom), 0);
    end
    wait_out();
    check("gap_locked", 32'(locked), 1);
    drive(1, 1, gen ^ 8'h10, 0);
    gen = nxt(gen);
    drive(1, 1, gen ^ 8'h10, 1);
    gen = nxt(gen);
    wait_out();
    check("clear_with_err_pulse", 32'(error), 1);
    check("clear_with_err_count", 32'(error_count), 0);

    // Reset while locked with seven errors counted
    do_reset();
    lock_up();
    repeat (7) begin
      drive(1, 1, gen ^ 8'h02, 0); gen = nxt(gen);
      send_good();
    end
    wait_out();
    check("seven_err_count", 32'(error_count), 32'(exp_cnt(7)));
    drive(0, 1, gen, 0);
    wait_out();
    check("midreset_locked", 32'(locked), 0);
    check("midreset_count", 32'(error_count), 0);

    // Randomized segments with varying corruption rates
    gen = 8'($urandom);
    if (gen == 8'hFF) gen = 8'h00;
    for (int seg = 0; seg < 16; seg++) begin
      case (seg % 4)
        0: pct = 0;
        1: pct = 3;
        2: pct = 40;
        default: pct = 90;
      endcase
      for (int c = 0; c < 150; c++) begin
        r = $urandom_range(0, 999);
        if (r < 3) drive(0, $urandom_range(0, 1), 8'($urandom), 0);
        else if (r < 120) drive(1, 0, 8'($urandom), ($urandom_range(0, 9) == 0));
        else if (r < 130) drive(1, 1, 8'hFF, ($urandom_range(0, 9) == 0));
        else begin
          if ($urandom_range(0, 99) < pct)
            drive(1, 1, gen ^ 8'($urandom_range(1, 255)), ($urandom_range(0, 19) == 0));
          else
            drive(1, 1, gen, ($urandom_range(0, 19) == 0));
          gen = nxt(gen);
        end
      end
    end

    drive(1, 0, 8'h00, 0);
    for (int i = 0; i < 10 && sb.size() > 0; i++) wait_out();
    wait_out();
    check("scoreboard_drained", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
